// File: rtl/riscv_cpu_pkg.sv
// Shared types and widths for the RISC-V pipeline: EX->MEM and MEM->WB bundles,
// load/store size encoding and the LSU handshake states.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    mem_size_e             size;
    logic                  sign_ext;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_ctrl_t;

  typedef struct packed {
    logic                     rf_we;
    logic [RF_ADDR_WIDTH-1:0] rf_waddr;
    wb_sel_e                  wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    mem_ctrl_t             mem_ctrl;
    logic [DATA_WIDTH-1:0] alu_result;
    wb_ctrl_t              wb_pipeline;
  } ex2mem_t;

  typedef struct packed {
    logic                     rf_we;
    logic [RF_ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]    wb_data;
  } mem2wb_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the LSU: byte enables, store-data lane
// replication, load-data extraction/extension and the misalignment flag.
module lsu_align
  import riscv_cpu_pkg::*;
(
  input  mem_size_e             size,
  input  logic                  sign_ext,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata_rep,
  output logic [DATA_WIDTH-1:0] rdata_ext,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Lane selection and extension per access size
  always_comb begin
    be         = {BE_WIDTH{1'b0}};
    wdata_rep  = wdata;
    rdata_ext  = shifted;
    misaligned = 1'b0;
    case (size)
      MEM_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {BE_WIDTH{wdata[7:0]}};
        rdata_ext = {{(DATA_WIDTH-8){sign_ext & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {(BE_WIDTH/2){wdata[15:0]}};
        rdata_ext  = {{(DATA_WIDTH-16){sign_ext & shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      MEM_W: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // Unused size encoding is rejected like a misaligned access
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the req/gnt/rvalid data bus for loads and stores,
// stalls upstream while a transaction is in flight and registers the WB bundle.
module mem_stage
  import riscv_cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ex2mem_t               mem_pipeline_i,
  output mem2wb_t               wb_pipeline_o,
  output logic                  stall_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  mem_ctrl_t             ctrl;
  wb_ctrl_t              wbc;
  logic [DATA_WIDTH-1:0] alu;
  lsu_state_e            state_q, state_d;
  mem2wb_t               wb_q, wb_d;
  logic                  err_q, err_d;
  logic                  misaligned, aligned_op, complete;
  logic [DATA_WIDTH-1:0] load_data;

  assign ctrl = mem_pipeline_i.mem_ctrl;
  assign wbc  = mem_pipeline_i.wb_pipeline;
  assign alu  = mem_pipeline_i.alu_result;

  lsu_align u_align (
    .size      (ctrl.size),
    .sign_ext  (ctrl.sign_ext),
    .addr_lo   (alu[1:0]),
    .wdata     (ctrl.wdata),
    .rdata     (data_rdata_i),
    .be        (data_be_o),
    .wdata_rep (data_wdata_o),
    .rdata_ext (load_data),
    .misaligned(misaligned)
  );

  // Bus fields come straight from the held EX bundle, so they stay stable in WAIT_GNT
  assign data_addr_o = {alu[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o   = ctrl.we;
  assign aligned_op  = ctrl.req & ~misaligned;
  assign stall_o     = aligned_op & ~complete;

  // Handshake FSM next state and bus request
  always_comb begin
    state_d    = state_q;
    data_req_o = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_op) begin
          data_req_o = 1'b1;
          state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          state_d = WAIT_RVALID;
        end else begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = WAIT_RVALID;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next WB bundle and error pulse
  always_comb begin
    wb_d  = '0;
    err_d = 1'b0;
    if (complete) begin
      wb_d.rf_waddr = wbc.rf_waddr;
      if (data_err_i) begin
        err_d = 1'b1;
      end else if (!ctrl.we) begin
        wb_d.rf_we   = wbc.rf_we;
        wb_d.wb_data = (wbc.wb_sel == WB_MEM) ? load_data : alu;
      end else begin
        wb_d.rf_we = 1'b0;
      end
    end else if (stall_o) begin
      wb_d = '0;
    end else if (ctrl.req) begin
      // Only a misaligned access reaches here: no bus cycle, write suppressed
      err_d = 1'b1;
    end else begin
      wb_d.rf_we    = wbc.rf_we;
      wb_d.rf_waddr = wbc.rf_waddr;
      wb_d.wb_data  = alu;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  assign wb_pipeline_o = wb_q;
  assign lsu_err_o     = err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the registered ex2mem_t bundle from EX and performs data-memory loads and stores over a req/gnt/rvalid bus.
- Forwards the ALU result or the aligned, extended load data to WB through a registered mem2wb_t bundle.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- None local. DATA_WIDTH (32) and ADDR_WIDTH (32) come from riscv_cpu_pkg.

Ports:
- clk_i  in  1  clock, single domain.
- rst_ni  in  1  asynchronous reset, active low.
- mem_pipeline_i  in  ex2mem_t  EX→MEM bundle: mem_ctrl {req, we, size, sign_ext, wdata}, alu_result, wb_pipeline {rf_we, rf_waddr, wb_sel}.
- wb_pipeline_o  out  mem2wb_t  registered MEM→WB bundle: {rf_we, rf_waddr, wb_data}.
- stall_o  out  1  upstream must hold mem_pipeline_i.
- lsu_err_o  out  1  registered one-cycle pulse on misaligned access or bus error.
- data_req_o  out  1  bus request.
- data_gnt_i  in  1  request accepted.
- data_rvalid_i  in  1  response valid (loads and stores).
- data_err_i  in  1  response error, qualified by rvalid.
- data_we_o  out  1  1 = store.
- data_be_o  out  4  byte enables.
- data_addr_o  out  ADDR_WIDTH  word-aligned address, alu_result with [1:0] forced to 0.
- data_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- data_rdata_i  in  DATA_WIDTH  load data.

Behaviour:
- Reset: state=IDLE; wb_pipeline_o all zero (rf_we=0); lsu_err_o=0; data_req_o=0. Async reset mid-transaction abandons it. A later rvalid in IDLE is ignored.
- Bubble: all-zero ex2mem_t (mem_ctrl.req=0, rf_we=0).
- Non-memory op (mem_ctrl.req=0): 1-cycle latency. Output register loads {rf_we, rf_waddr, wb_data=alu_result}. stall_o=0.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0. No bus request; rf_we suppressed; lsu_err_o pulses next cycle; stall_o=0.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load data: shift data_rdata_i right by addr[1:0]*8. Sign-extend if sign_ext=1, else zero-extend, from bit 7 (byte) or 15 (half).
- FSM {IDLE, WAIT_GNT, WAIT_RVALID}:
  - IDLE, aligned mem op: data_req_o=1 combinationally. gnt=1 → WAIT_RVALID; gnt=0 → WAIT_GNT.
  - WAIT_GNT: data_req_o=1, with addr/we/be/wdata held stable. On gnt → WAIT_RVALID.
  - WAIT_RVALID: data_req_o=0. On rvalid → IDLE; output register loads the completed op.
- gnt and rvalid are never accepted in the same cycle for the same request. rvalid is earliest the cycle after gnt.
- stall_o=1 whenever mem_ctrl.req=1 and the access is aligned, except the cycle where state=WAIT_RVALID and data_rvalid_i=1. The output register loads a bubble during every stalled cycle.
- Completion with data_err_i=1: rf_we=0, wb_data=0, lsu_err_o pulses.
- Stores complete with rf_we forced 0.
- Back-to-back mem ops: the next op is requested in IDLE the cycle after completion. No request overlap; at most one outstanding transaction.

Decomposition:
- riscv_cpu_pkg adds:
  - mem_size_e {MEM_B, MEM_H, MEM_W}
  - mem_ctrl_t
  - mem2wb_t
  - lsu_state_e
  - BE_WIDTH = DATA_WIDTH/8
- One combinational sub-module, lsu_align: computes be, replicated wdata, extracted/extended rdata and the misaligned flag from size, sign_ext and addr[1:0].
- mem_stage holds the FSM, stall logic and output register.

Test Plan:
- Reset asserted mid-WAIT_RVALID, then rvalid=1 after release → wb_pipeline_o stays zero, data_req_o=0, state IDLE.
- ALU op alu_result=0x1234_5678, rf_waddr=5, rf_we=1 → next cycle wb_data=0x1234_5678, rf_we=1, stall_o=0 throughout.
- Signed byte load addr=0x1003, gnt delayed 2 cycles, rdata=0x80AA_BBCC → data_addr_o=0x1000, be=4'b1000, stall_o high 4 cycles, wb_data=0xFFFF_FF80.
- Half store addr=0x2002, wdata=0x0000_ABCD, immediate gnt, rvalid next cycle → be=4'b1100, data_wdata_o=0xABCD_ABCD, rf_we=0 at completion.
- Word load addr=0x3001 → no data_req_o, lsu_err_o=1 one cycle, rf_we=0, stall_o=0.
- Unsigned half load addr=0x4000, rvalid with data_err_i=1 → rf_we=0, wb_data=0, lsu_err_o pulse; following ALU op completes next cycle.
